// File: rtl/tp_probe_pkg.sv
// tp_probe_pkg: config-entry field layout, reset select mapping and legal parameter ranges
// shared by tp_probe_mux and tp_stretch.
package tp_probe_pkg;

    localparam int NSIG_MIN    = 2;
    localparam int NSIG_MAX    = 256;
    localparam int NTP_MIN     = 1;
    localparam int NTP_MAX     = 32;
    localparam int STRETCH_MIN = 2;
    localparam int STRETCH_MAX = 255;

    localparam int STRETCH_CW  = $clog2(STRETCH_MAX + 1);

    // Config entry is {TRI, MODE, SEL}, SEL in the low bits.
    localparam int SEL_LSB = 0;

    function automatic int mode_bit(input int selw);
        return selw;
    endfunction

    function automatic int tri_bit(input int selw);
        return selw + 1;
    endfunction

    function automatic int reset_sel(input int pin, input int nsig);
        return pin % nsig;
    endfunction

    function automatic bit cfg_ok(input int nsig, input int ntp, input int stretch);
        return (nsig >= NSIG_MIN) && (nsig <= NSIG_MAX) &&
               (ntp >= NTP_MIN) && (ntp <= NTP_MAX) &&
               (stretch >= STRETCH_MIN) && (stretch <= STRETCH_MAX);
    endfunction

endpackage

// File: rtl/tp_stretch.sv
// tp_stretch: per-pin retriggerable pulse stretcher; a rising edge keeps the output high
// for STRETCH cycles, or for the level width if that is longer.
module tp_stretch
    import tp_probe_pkg::*;
#(
    parameter int STRETCH = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_level,
    input  logic i_load,
    input  logic i_hold,
    output logic o_level
);

    localparam int CW = STRETCH_CW;

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_prev;

    // A load (config write) clears the count and the edge history takes the new level below.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (i_load) begin
            w_cnt_nxt = '0;
        end else if (i_level && !r_prev) begin
            w_cnt_nxt = CW'(STRETCH);
        end else if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - CW'(1);
        end
    end

    assign o_level = i_level | (w_cnt_nxt != '0);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt  <= '0;
            r_prev <= 1'b0;
        end else if (!i_hold) begin
            r_cnt  <= w_cnt_nxt;
            r_prev <= i_level;
        end
    end

endmodule

// File: rtl/tp_probe_mux.sv
// tp_probe_mux: run-time test-point multiplexer routing NSIG probes onto NTP pins with
// per-pin select, output enable and pulse stretch. Define TP_STRETCH_EN to build the stretchers.
module tp_probe_mux
    import tp_probe_pkg::*;
#(
    parameter  int NSIG    = 64,
    parameter  int NTP     = 16,
    parameter  int STRETCH = 8,
    localparam int SELW    = $clog2(NSIG),
    localparam int AW      = (NTP > 1) ? $clog2(NTP) : 1,
    localparam int CW      = SELW + 2
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [NSIG-1:0] i_probe_in,
    input  logic            i_freeze,
    input  logic            i_cfg_we,
    input  logic [AW-1:0]   i_cfg_addr,
    input  logic [CW-1:0]   i_cfg_wdata,
    output logic [CW-1:0]   o_cfg_rdata,
    output logic [NTP-1:0]  o_tp_out,
    output logic [NTP-1:0]  o_tp_t
);

    localparam int MODE_B = mode_bit(SELW);
    localparam int TRI_B  = tri_bit(SELW);
    localparam bit CFG_OK = cfg_ok(NSIG, NTP, STRETCH);

    logic [SELW-1:0] r_sel [NTP];
    logic [NTP-1:0]  r_mode;
    logic [NTP-1:0]  r_tri;
    logic [NTP-1:0]  r_tp_out;
    logic [NSIG-1:0] r_probe;
    logic [CW-1:0]   r_rdata;

    logic [NTP-1:0]  w_match;
    logic            w_addr_ok;
    logic            w_wr;
    logic [NTP-1:0]  w_hit;
    logic [CW-1:0]   w_rd_entry;
    logic [NTP-1:0]  w_cur;
    logic [NTP-1:0]  w_out_nxt;

    // Address decode; out-of-range addresses match no pin, so writes drop and reads return 0.
    always_comb begin
        w_match    = '0;
        w_rd_entry = '0;
        for (int i = 0; i < NTP; i++) begin
            w_match[i] = (i_cfg_addr == AW'(i));
            if (w_match[i]) begin
                w_rd_entry = {r_tri[i], r_mode[i], r_sel[i]};
            end
        end
    end

    assign w_addr_ok = |w_match;
    assign w_wr      = i_cfg_we && w_addr_ok && CFG_OK;
    assign w_hit     = w_wr ? w_match : '0;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < NTP; i++) begin
                r_sel[i] <= SELW'(reset_sel(i, NSIG));
            end
            r_mode <= '0;
            r_tri  <= '0;
        end else begin
            for (int i = 0; i < NTP; i++) begin
                if (w_hit[i]) begin
                    r_sel[i]  <= i_cfg_wdata[SEL_LSB +: SELW];
                    r_mode[i] <= i_cfg_wdata[MODE_B];
                    r_tri[i]  <= i_cfg_wdata[TRI_B];
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rdata <= '0;
        end else if (w_wr) begin
            r_rdata <= i_cfg_wdata;
        end else begin
            r_rdata <= w_rd_entry;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_probe <= '0;
        end else begin
            r_probe <= i_probe_in;
        end
    end

    // Select values at or above NSIG match no source and yield constant 0.
    always_comb begin
        w_cur = '0;
        for (int i = 0; i < NTP; i++) begin
            for (int s = 0; s < NSIG; s++) begin
                if (r_sel[i] == SELW'(s)) begin
                    w_cur[i] = r_probe[s];
                end
            end
        end
    end

`ifdef TP_STRETCH_EN
    logic [NTP-1:0] r_pend;
    logic [NTP-1:0] w_str;

    // A write arms a one-shot reload of the pin's stretcher, deferred while frozen.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pend <= '0;
        end else if (i_freeze) begin
            r_pend <= r_pend | w_hit;
        end else begin
            r_pend <= w_hit;
        end
    end

    for (genvar g = 0; g < NTP; g++) begin : g_str
        tp_stretch #(
            .STRETCH (STRETCH)
        ) u_stretch (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_level (w_cur[g]),
            .i_load  (r_pend[g]),
            .i_hold  (i_freeze),
            .o_level (w_str[g])
        );
    end

    assign w_out_nxt = (r_mode & w_str) | (~r_mode & w_cur);
`else
    assign w_out_nxt = w_cur;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_tp_out <= '0;
        end else if (!i_freeze) begin
            r_tp_out <= w_out_nxt;
        end
    end

    assign o_tp_out    = r_tp_out;
    assign o_tp_t      = r_tri;
    assign o_cfg_rdata = r_rdata;

endmodule

// File: doc/tp_probe_mux.md
# tp_probe_mux

Run-time configurable test-point multiplexer that routes any of NSIG internal probe signals onto NTP test-point pins, replacing the fixed, rebuild-per-debug-session test-point assignment. Each pin has its own source select, output-enable and optional pulse-stretch mode, set through a simple register write port (slow-control/JTAG side). It sits at the top level between the fabric probe bus and the test-point IOBUFs, driving their I and T inputs.

## Interface
- NSIG, 64: number of probe inputs (2..256)
- NTP, 16: number of test-point pins (1..32)
- STRETCH, 8: stretch length in CLK cycles (2..255)
- SELW, $clog2(NSIG): select field width (derived, not overridden)
- CLK  in  1  probe/config clock; all logic on rising edge
- RST  in  1  asynchronous, active-high reset
- PROBE_IN  in  NSIG  probe bus, CLK-domain signals
- FREEZE  in  1  high: hold pin outputs and stretch state
- CFG_WE  in  1  write strobe, one cycle per write
- CFG_ADDR  in  $clog2(NTP)  pin index for write and readback
- CFG_WDATA  in  SELW+2  {TRI, MODE, SEL}
- CFG_RDATA  out  SELW+2  config of pin CFG_ADDR, registered
- TP_OUT  out  NTP  to IOBUF I
- TP_T  out  NTP  to IOBUF T; 1 = tri-state, 0 = drive

## Operation
- Config entry per pin i: SEL (source index), MODE (0 direct, 1 stretch), TRI (copied to TP_T[i]).
- Reset values: SEL[i] = i mod NSIG, MODE = 0, TRI = 0; TP_OUT = 0, TP_T = 0, CFG_RDATA = 0, stretch counters 0, edge history 0.
- Write: CFG_WE=1 with CFG_ADDR < NTP updates that entry at the clock edge; CFG_ADDR >= NTP ignored. SEL >= NSIG selects constant 0.
- Readback: CFG_RDATA = entry[CFG_ADDR] one cycle after CFG_ADDR is presented; out-of-range address returns 0. A write and a readback of the same entry in one cycle returns the new value one cycle later.
- Pipeline: stage 1 registers PROBE_IN; stage 2 selects, applies mode, registers TP_OUT.
- Direct mode: TP_OUT[i] = registered selected probe.
- Stretch mode, per pin: rising edge (current 1, previous 0) loads counter with STRETCH; counter decrements to 0 each cycle; TP_OUT[i] = (counter != 0) OR current level. An edge during an active stretch reloads (retrigger). Output therefore stays high for max(level width, STRETCH) cycles.
- Writing an entry clears that pin's counter and loads its edge history with the newly selected level, so no false edge is generated by a select change.
- FREEZE=1: TP_OUT, counters and edge history hold; writes still update entries and TP_T immediately; new SEL/MODE take effect on the first cycle after FREEZE falls, with edge history reloaded then (no false edge).
- RST asserted mid-stretch or mid-freeze: everything returns to reset values immediately.

## Timing
- PROBE_IN to TP_OUT: 2 cycles, both modes (leading edge).
- Single-cycle pulse in stretch mode: TP_OUT high exactly STRETCH cycles.
- CFG write to TP_T change: 1 cycle. CFG write to new source visible on TP_OUT: 2 cycles.
- CFG_ADDR to CFG_RDATA: 1 cycle.

## Configuration
- TP_STRETCH_EN defined: stretch counters and edge logic built; MODE honoured.
- Not defined: no counters; MODE bit still stored and read back but ignored, all pins direct; STRETCH unused.

## Structure
- Package tp_probe_pkg: config field offsets (SEL low, MODE at SELW, TRI at SELW+1), reset-mapping function, range limits for NSIG/NTP/STRETCH.
- Sub-module tp_stretch: one instance per pin; inputs level, load/clear, hold; output stretched level; generated only under TP_STRETCH_EN.

## Test plan
- Reset release, default map: PROBE_IN = 64'h0000_0000_0000_A5C3 -> TP_OUT = 16'hA5C3 two cycles later, TP_T = 0.
- Remap: write pin 3 SEL=40, MODE=0; pulse PROBE_IN[40] for 3 cycles -> TP_OUT[3] high 3 cycles starting 2 cycles after the pulse; other pins unchanged.
- Stretch: pin 5 MODE=1, 1-cycle pulse on its source -> TP_OUT[5] high exactly 8 cycles; second pulse 4 cycles after first -> high 12 cycles total.
- Select change without false edge: pin 5 stretch mode, switch SEL from a low source to a steady-high source -> TP_OUT[5] follows level, no stretch tail after it falls.
- FREEZE: assert mid-stretch with counter at 5, hold 20 cycles -> TP_OUT frozen; release -> 5 further high cycles; write TRI=1 during freeze -> TP_T bit set next cycle.
- Bounds: write CFG_ADDR=NTP -> no entry changes, readback 0; SEL=NSIG -> pin reads constant 0; RST mid-stretch -> TP_OUT=0 immediately.
